// File: rtl/ahb_burst_rr_arbiter.sv
// ahb_burst_rr_arbiter
// Round-robin AHB arbiter in front of the single SDRAM controller port.
// Holds grant for a whole defined-length burst, caps undefined-length INCR
// tenures at MAX_INCR_BEATS accepted beats, and re-arbitrates on the same
// edge that releases the bus so ownership changes without dead cycles.
// All outputs come straight from flops.
module ahb_burst_rr_arbiter #(
    parameter int NUM_MASTERS    = 4,
    parameter int MAX_INCR_BEATS = 16
) (
    input  logic                                   hclk,
    input  logic                                   hresetn,
    input  logic [NUM_MASTERS-1:0]                 request,
    input  logic [NUM_MASTERS-1:0][1:0]            htrans,
    input  logic [NUM_MASTERS-1:0][2:0]            hburst,
    input  logic                                   slave_hready,
    output logic [NUM_MASTERS-1:0]                 grant,
    output logic [$clog2(NUM_MASTERS)-1:0]         selected_master,
    output logic                                   grant_valid,
    output logic [8:0]                             tenure_beats
);

    localparam int IDX_W = $clog2(NUM_MASTERS);

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;
    localparam logic [2:0] HBURST_INCR   = 3'b001;

    localparam logic [8:0]       MAX_INCR     = 9'(MAX_INCR_BEATS);
    localparam logic [8:0]       BEATS_SAT    = 9'd256;
    localparam logic [IDX_W:0]   NUM_M        = (IDX_W+1)'(NUM_MASTERS);
    localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(NUM_MASTERS - 1);
    localparam logic [NUM_MASTERS-1:0] ONE_HOT0 = NUM_MASTERS'(1);

    typedef enum logic {
        IDLE,
        OWNED
    } state_e;

    state_e                 state_q, state_d;
    logic [IDX_W-1:0]       ptr_q, ptr_d;
    logic [4:0]             len_q, len_d;
    logic                   incr_q, incr_d;
    logic [NUM_MASTERS-1:0] grant_d;
    logic [IDX_W-1:0]       sel_d;
    logic [8:0]             tenure_d;

    // Owner view, beat accounting and arbitration results
    logic [1:0]             owner_trans;
    logic [2:0]             owner_burst;
    logic                   owner_req;
    logic [IDX_W-1:0]       owner_next;
    logic                   accept;
    logic [8:0]             beats_acc;
    logic [4:0]             len_acc;
    logic                   incr_acc;
    logic                   release_now;
    logic [IDX_W-1:0]       arb_start;
    logic                   arb_found;
    logic [IDX_W-1:0]       arb_idx;

    // Defined burst length; 0 marks INCR (undefined length)
    function automatic logic [4:0] burst_len(input logic [2:0] hb);
        case (hb)
            3'b000:         return 5'd1;
            3'b010, 3'b011: return 5'd4;
            3'b100, 3'b101: return 5'd8;
            3'b110, 3'b111: return 5'd16;
            default:        return 5'd0;
        endcase
    endfunction

    // State register and all registered outputs
    always_ff @(posedge hclk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!hresetn) begin
            state_q         <= IDLE;
            ptr_q           <= '0;
            len_q           <= '0;
            incr_q          <= 1'b0;
            grant           <= '0;
            selected_master <= '0;
            tenure_beats    <= '0;
        end else begin
            state_q         <= state_d;
            ptr_q           <= ptr_d;
            len_q           <= len_d;
            incr_q          <= incr_d;
            grant           <= grant_d;
            selected_master <= sel_d;
            tenure_beats    <= tenure_d;
        end
    end

    // Next-state: beat acceptance, release decision and round-robin search
    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d     = state_q;
        owner_trans = htrans[selected_master];
        owner_burst = hburst[selected_master];
        owner_req   = request[selected_master];
        owner_next  = (selected_master == LAST_IDX) ? '0 : selected_master + 1'b1;
        beats_acc   = tenure_beats;
        len_acc     = len_q;
        incr_acc    = incr_q;
        accept      = 1'b0;

        if (owner_trans == HTRANS_NONSEQ) begin
            accept    = slave_hready;
            beats_acc = 9'd1;
            len_acc   = burst_len(owner_burst);
            incr_acc  = (owner_burst == HBURST_INCR);
        end else if (owner_trans == HTRANS_SEQ) begin
            accept    = slave_hready;
            beats_acc = (tenure_beats == BEATS_SAT) ? tenure_beats : tenure_beats + 9'd1;
        end

        release_now = (accept && !incr_acc && (beats_acc >= {4'd0, len_acc}))
                   || (accept && incr_acc && (beats_acc >= MAX_INCR))
                   || (owner_trans == HTRANS_IDLE)
                   || !owner_req;

        // Search from the pointer upward; after a release the old owner comes last
        arb_start = (state_q == OWNED) ? owner_next : ptr_q;
        arb_found = 1'b0;
        arb_idx   = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            logic [IDX_W:0] cand;
            cand = {1'b0, arb_start} + (IDX_W+1)'(i);
            if (cand >= NUM_M) cand = cand - NUM_M;
            if (!arb_found && request[cand[IDX_W-1:0]]) begin
                arb_found = 1'b1;
                arb_idx   = cand[IDX_W-1:0];
            end
        end

        case (state_q)
            IDLE:    if (slave_hready && arb_found) state_d = OWNED;
            OWNED:   if (slave_hready && release_now && !arb_found) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values of grant, select, pointer and tenure; all frozen while hready is low
    always_comb begin
        grant_d  = grant;
        sel_d    = selected_master;
        ptr_d    = ptr_q;
        tenure_d = tenure_beats;
        len_d    = len_q;
        incr_d   = incr_q;

        if (slave_hready) begin
            if (state_q == IDLE) begin
                if (arb_found) begin
                    grant_d = ONE_HOT0 << arb_idx;
                    sel_d   = arb_idx;
                end else begin
                    grant_d = '0;
                end
            end else begin
                tenure_d = beats_acc;
                len_d    = len_acc;
                incr_d   = incr_acc;
                if (release_now) begin
                    ptr_d = owner_next;
                    if (arb_found) begin
                        grant_d = ONE_HOT0 << arb_idx;
                        sel_d   = arb_idx;
                    end else begin
                        grant_d  = '0;
                        tenure_d = '0;
                    end
                end
            end
        end
    end

    assign grant_valid = (state_q == OWNED);

endmodule

// File: tb/tb_ahb_burst_rr_arbiter.sv
// tb_ahb_burst_rr_arbiter
// Table of {inputs, expected registered outputs after the edge} records,
// replayed through a scoreboard queue, followed by a hand-written sequence
// for early burst termination, a wait state with vanishing requests, and
// release on a dropped request.
module tb_ahb_burst_rr_arbiter;

    localparam int NM = 4;

    localparam logic [1:0] T_IDLE = 2'b00;
    localparam logic [1:0] T_BUSY = 2'b01;
    localparam logic [1:0] T_NS   = 2'b10;
    localparam logic [1:0] T_SEQ  = 2'b11;

    localparam logic [2:0] B_SINGLE = 3'b000;
    localparam logic [2:0] B_INCR   = 3'b001;
    localparam logic [2:0] B_INCR4  = 3'b011;
    localparam logic [2:0] B_WRAP8  = 3'b100;
    localparam logic [2:0] B_INCR8  = 3'b101;

    typedef struct {
        logic        rstn;
        logic        hready;
        logic [3:0]  req;
        logic [7:0]  ht;
        logic [11:0] hb;
        logic [3:0]  grant;
        logic [1:0]  sel;
        logic        gv;
        logic [8:0]  beats;
    } vec_t;

    logic                 hclk = 1'b0;
    logic                 hresetn;
    logic [NM-1:0]        request;
    logic [NM-1:0][1:0]   htrans;
    logic [NM-1:0][2:0]   hburst;
    logic                 slave_hready;
    logic [NM-1:0]        grant;
    logic [1:0]           selected_master;
    logic                 grant_valid;
    logic [8:0]           tenure_beats;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   checks  = 0;
    int   errors  = 0;
    int   step_no = 0;

    ahb_burst_rr_arbiter #(
        .NUM_MASTERS    (NM),
        .MAX_INCR_BEATS (16)
    ) dut (
        .hclk            (hclk),
        .hresetn         (hresetn),
        .request         (request),
        .htrans          (htrans),
        .hburst          (hburst),
        .slave_hready    (slave_hready),
        .grant           (grant),
        .selected_master (selected_master),
        .grant_valid     (grant_valid),
        .tenure_beats    (tenure_beats)
    );

    always #5 hclk = ~hclk;

    // One master's htrans placed in the packed vector, all others IDLE
    function automatic logic [7:0] ht1(input int m, input logic [1:0] t);
        logic [7:0] v;
        v = '0;
        v[2*m +: 2] = t;
        return v;
    endfunction

    function automatic logic [11:0] hb1(input int m, input logic [2:0] b);
        logic [11:0] v;
        v = '0;
        v[3*m +: 3] = b;
        return v;
    endfunction

    function automatic vec_t mk(input logic rstn, input logic hready, input logic [3:0] req,
                                input logic [7:0] ht, input logic [11:0] hb,
                                input logic [3:0] g, input logic [1:0] s, input logic gv,
                                input int b);
        vec_t v;
        v.rstn = rstn; v.hready = hready; v.req = req; v.ht = ht; v.hb = hb;
        v.grant = g; v.sel = s; v.gv = gv; v.beats = 9'(b);
        return v;
    endfunction

    task automatic add(input logic rstn, input logic hready, input logic [3:0] req,
                       input logic [7:0] ht, input logic [11:0] hb,
                       input logic [3:0] g, input logic [1:0] s, input logic gv, input int b);
        vecs.push_back(mk(rstn, hready, req, ht, hb, g, s, gv, b));
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL step %0d %s: got %0h expected %0h", step_no, name, act, expv);
        end
    endtask

    // Drive one cycle of stimulus, queue its expectation, compare #1 after the edge
    task automatic apply(input vec_t v);
        vec_t e;
        hresetn      = v.rstn;
        slave_hready = v.hready;
        request      = v.req;
        htrans       = v.ht;
        hburst       = v.hb;
        exp_q.push_back(v);
        @(posedge hclk);
        #1;
        e = exp_q.pop_front();
        check("grant",           32'(grant),           32'(e.grant));
        check("selected_master", 32'(selected_master), 32'(e.sel));
        check("grant_valid",     32'(grant_valid),     32'(e.gv));
        check("tenure_beats",    32'(tenure_beats),    32'(e.beats));
        step_no++;
    endtask

    initial begin
        // Reset held for three edges with everyone requesting
        for (int i = 0; i < 3; i++) add(1'b0, 1'b1, 4'hF, 8'hAA, 12'h000, 4'b0000, 2'd0, 1'b0, 0);
        // First edge out of reset, then round-robin over continuous SINGLEs
        add(1'b1, 1'b1, 4'hF, 8'hAA, 12'h000, 4'b0001, 2'd0, 1'b1, 0);
        add(1'b1, 1'b1, 4'hF, 8'hAA, 12'h000, 4'b0010, 2'd1, 1'b1, 1);
        add(1'b1, 1'b1, 4'hF, 8'hAA, 12'h000, 4'b0100, 2'd2, 1'b1, 1);
        add(1'b1, 1'b1, 4'hF, 8'hAA, 12'h000, 4'b1000, 2'd3, 1'b1, 1);
        add(1'b1, 1'b1, 4'hF, 8'hAA, 12'h000, 4'b0001, 2'd0, 1'b1, 1);
        // Owner goes IDLE, nobody requests: park on master 0, pointer now 1
        add(1'b1, 1'b1, 4'h0, 8'h00, 12'h000, 4'b0000, 2'd0, 1'b0, 0);

        // Burst hold: master 1 INCR8 with master 2 waiting
        add(1'b1, 1'b1, 4'b0110, 8'h00, 12'h000, 4'b0010, 2'd1, 1'b1, 0);
        add(1'b1, 1'b1, 4'b0110, ht1(1, T_NS), hb1(1, B_INCR8), 4'b0010, 2'd1, 1'b1, 1);
        for (int b = 2; b <= 7; b++)
            add(1'b1, 1'b1, 4'b0110, ht1(1, T_SEQ), hb1(1, B_INCR8), 4'b0010, 2'd1, 1'b1, b);
        add(1'b1, 1'b1, 4'b0110, ht1(1, T_SEQ), hb1(1, B_INCR8), 4'b0100, 2'd2, 1'b1, 8);
        // Master 2 leaves, bus idles and parks on master 2, pointer now 3
        add(1'b1, 1'b1, 4'b0000, 8'h00, 12'h000, 4'b0000, 2'd2, 1'b0, 0);

        // Wait states: master 0 INCR4, five low-hready cycles after beat 2, master 3 waiting
        add(1'b1, 1'b1, 4'b0001, 8'h00, 12'h000, 4'b0001, 2'd0, 1'b1, 0);
        add(1'b1, 1'b1, 4'b1001, ht1(0, T_NS),  hb1(0, B_INCR4), 4'b0001, 2'd0, 1'b1, 1);
        add(1'b1, 1'b1, 4'b1001, ht1(0, T_SEQ), hb1(0, B_INCR4), 4'b0001, 2'd0, 1'b1, 2);
        for (int i = 0; i < 5; i++)
            add(1'b1, 1'b0, 4'b1001, ht1(0, T_SEQ), hb1(0, B_INCR4), 4'b0001, 2'd0, 1'b1, 2);
        add(1'b1, 1'b1, 4'b1001, ht1(0, T_SEQ), hb1(0, B_INCR4), 4'b0001, 2'd0, 1'b1, 3);
        add(1'b1, 1'b1, 4'b1001, ht1(0, T_SEQ), hb1(0, B_INCR4), 4'b1000, 2'd3, 1'b1, 4);
        // Master 3 leaves, park on 3, pointer now 0
        add(1'b1, 1'b1, 4'b0000, 8'h00, 12'h000, 4'b0000, 2'd3, 1'b0, 0);

        // INCR cap: master 2 streams INCR with one BUSY, master 0 waiting
        add(1'b1, 1'b1, 4'b0100, 8'h00, 12'h000, 4'b0100, 2'd2, 1'b1, 0);
        add(1'b1, 1'b1, 4'b0101, ht1(2, T_NS), hb1(2, B_INCR), 4'b0100, 2'd2, 1'b1, 1);
        for (int b = 2; b <= 8; b++)
            add(1'b1, 1'b1, 4'b0101, ht1(2, T_SEQ), hb1(2, B_INCR), 4'b0100, 2'd2, 1'b1, b);
        add(1'b1, 1'b1, 4'b0101, ht1(2, T_BUSY), hb1(2, B_INCR), 4'b0100, 2'd2, 1'b1, 8);
        for (int b = 9; b <= 15; b++)
            add(1'b1, 1'b1, 4'b0101, ht1(2, T_SEQ), hb1(2, B_INCR), 4'b0100, 2'd2, 1'b1, b);
        add(1'b1, 1'b1, 4'b0101, ht1(2, T_SEQ), hb1(2, B_INCR), 4'b0001, 2'd0, 1'b1, 16);

        // Reset on beat 3 of a master 0 WRAP8; pointer must restart at 0 (else master 3 wins)
        add(1'b1, 1'b1, 4'hF, ht1(0, T_NS),  hb1(0, B_WRAP8), 4'b0001, 2'd0, 1'b1, 1);
        add(1'b1, 1'b1, 4'hF, ht1(0, T_SEQ), hb1(0, B_WRAP8), 4'b0001, 2'd0, 1'b1, 2);
        add(1'b0, 1'b1, 4'hF, ht1(0, T_SEQ), hb1(0, B_WRAP8), 4'b0000, 2'd0, 1'b0, 0);
        add(1'b1, 1'b1, 4'hF, 8'h00, 12'h000, 4'b0001, 2'd0, 1'b1, 0);

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

        // Early termination: INCR8 cut short by a new NONSEQ INCR4, which must reload length 4
        apply(mk(1'b1, 1'b1, 4'hF, ht1(0, T_NS),  hb1(0, B_INCR8), 4'b0001, 2'd0, 1'b1, 1));
        apply(mk(1'b1, 1'b1, 4'hF, ht1(0, T_SEQ), hb1(0, B_INCR8), 4'b0001, 2'd0, 1'b1, 2));
        apply(mk(1'b1, 1'b1, 4'hF, ht1(0, T_SEQ), hb1(0, B_INCR8), 4'b0001, 2'd0, 1'b1, 3));
        apply(mk(1'b1, 1'b1, 4'hF, ht1(0, T_NS),  hb1(0, B_INCR4), 4'b0001, 2'd0, 1'b1, 1));
        // Wait state while every request and htrans vanishes: nothing may move
        apply(mk(1'b1, 1'b0, 4'h0, 8'h00, 12'h000, 4'b0001, 2'd0, 1'b1, 1));
        apply(mk(1'b1, 1'b1, 4'hF, ht1(0, T_SEQ), hb1(0, B_INCR4), 4'b0001, 2'd0, 1'b1, 2));
        apply(mk(1'b1, 1'b1, 4'hF, ht1(0, T_SEQ), hb1(0, B_INCR4), 4'b0001, 2'd0, 1'b1, 3));
        apply(mk(1'b1, 1'b1, 4'hF, ht1(0, T_SEQ), hb1(0, B_INCR4), 4'b0010, 2'd1, 1'b1, 4));
        // Owner's request drops while its htrans shows BUSY: release to master 2, count held
        apply(mk(1'b1, 1'b1, 4'b1101, ht1(1, T_BUSY), hb1(1, B_INCR4), 4'b0100, 2'd2, 1'b1, 4));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
